wb_stage_multilane: RTL and testbench

//   Parametrised write-back stage for a LANES-wide pipeline; successor to the single-lane WB.

---
 rtl/wb_stage_multilane_if.sv | 44 ++++
 rtl/wb_stage_multilane.sv | 179 +++++++++++++++++
 tb/tb_wb_stage_multilane.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_multilane_if.sv
// Bundle bus between MEM, the multi-lane WB stage, the register file / ID
// forwarding network and the single-port debug trace.
interface wb_stage_multilane_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int PC_W   = 32
);
    localparam int L  = 2 + AW + DATA_W + PC_W;
    localparam int RW = 1 + AW + DATA_W;

    logic                  wb_allowin;
    logic                  mem_to_wb_valid;
    logic [LANES*L-1:0]    mem_to_wb_zip;
    logic [LANES*RW-1:0]   wb_rf_zip;
    logic [PC_W-1:0]       debug_wb_pc;
    logic [3:0]            debug_wb_rf_we;
    logic [AW-1:0]         debug_wb_rf_wnum;
    logic [DATA_W-1:0]     debug_wb_rf_wdata;

    // Upstream / observer side: offers bundles, consumes writes and trace.
    modport master (
        input  wb_allowin,
        output mem_to_wb_valid,
        output mem_to_wb_zip,
        input  wb_rf_zip,
        input  debug_wb_pc,
        input  debug_wb_rf_we,
        input  debug_wb_rf_wnum,
        input  debug_wb_rf_wdata
    );

    // WB stage side.
    modport slave (
        output wb_allowin,
        input  mem_to_wb_valid,
        input  mem_to_wb_zip,
        output wb_rf_zip,
        output debug_wb_pc,
        output debug_wb_rf_we,
        output debug_wb_rf_wnum,
        output debug_wb_rf_wdata
    );
endinterface

// File: rtl/wb_stage_multilane.sv
// Multi-lane write-back stage: latches one MEM->WB bundle, commits all lane
// register writes in a single cycle (youngest writer wins, r0 never written),
// and serialises retired lanes through a trace queue onto one debug port.
module wb_stage_multilane #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    wb_stage_multilane_if.slave  bus
);
    localparam int L         = 2 + AW + DATA_W + PC_W;
    localparam int RW        = 1 + AW + DATA_W;
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int OFS_WDATA = PC_W;
    localparam int OFS_WADDR = PC_W + DATA_W;
    localparam int OFS_WE    = PC_W + DATA_W + AW;
    localparam int OFS_V     = L - 1;

    // Pointer advance modulo DEPTH; off never exceeds DEPTH so one
    // subtraction is enough, and DEPTH need not be a power of two.
    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] ptr, input int off);
        int s;
        s = int'(ptr) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return CW'(s);
    endfunction

    // Latched bundle (data only, no reset) and its valid flag
    logic [LANES*L-1:0] bundle_q;
    logic               wb_valid_q, wb_valid_d;

    // Trace queue storage and control
    logic [PC_W-1:0]    tr_pc_q    [DEPTH];
    logic [AW-1:0]      tr_waddr_q [DEPTH];
    logic [DATA_W-1:0]  tr_wdata_q [DEPTH];
    logic               tr_we_q    [DEPTH];
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      wr_ptr_q, wr_ptr_d;

    // Unpacked lane fields
    logic               lane_v     [LANES];
    logic               lane_we    [LANES];
    logic [AW-1:0]      lane_waddr [LANES];
    logic [DATA_W-1:0]  lane_wdata [LANES];
    logic [PC_W-1:0]    lane_pc    [LANES];

    logic [CW-1:0]      nv;
    logic [CW-1:0]      free_slots;
    logic               ready_go;
    logic               allowin;
    logic               fire;
    logic               pop;
    logic               we_eff     [LANES];
    logic               push_en    [LANES];
    logic [CW-1:0]      push_idx   [LANES];
    logic [LANES*RW-1:0] rf_zip;

    // Split the latched bundle into per-lane fields and count valid lanes
    always_comb begin
        int n;
        n = 0;
        for (int i = 0; i < LANES; i++) begin
            lane_v[i]     = bundle_q[i*L + OFS_V];
            lane_we[i]    = bundle_q[i*L + OFS_WE];
            lane_waddr[i] = bundle_q[i*L + OFS_WADDR +: AW];
            lane_wdata[i] = bundle_q[i*L + OFS_WDATA +: DATA_W];
            lane_pc[i]    = bundle_q[i*L +: PC_W];
            if (lane_v[i]) n = n + 1;
        end
        nv = CW'(n);
    end

    // Handshake: stall only when the queue cannot take every valid lane
    // (no credit is given for the entry popped in the same cycle)
    always_comb begin
        free_slots = CW'(DEPTH) - count_q;
        ready_go   = (nv <= free_slots);
        allowin    = ~wb_valid_q | ready_go;
        fire       = wb_valid_q & ready_go;
        pop        = (count_q != '0);
    end

    // Effective RF write enables: a younger lane to the same address masks an older one
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            we_eff[i] = fire & lane_v[i] & lane_we[i] & (lane_waddr[i] != '0);
            for (int j = i + 1; j < LANES; j++) begin
                if (lane_v[j] && lane_we[j] && (lane_waddr[j] == lane_waddr[i]))
                    we_eff[i] = 1'b0;
            end
        end
    end

    // Assign consecutive queue slots to valid lanes in ascending lane order
    always_comb begin
        int k;
        k = 0;
        for (int i = 0; i < LANES; i++) begin
            push_en[i]  = fire & lane_v[i];
            push_idx[i] = wrap_add(wr_ptr_q, k);
            if (lane_v[i]) k = k + 1;
        end
    end

    // Next-state for the control registers
    always_comb begin
        wb_valid_d = allowin ? bus.mem_to_wb_valid : wb_valid_q;
        count_d    = count_q + (fire ? nv : CW'(0)) - CW'(pop);
        wr_ptr_d   = fire ? wrap_add(wr_ptr_q, int'(nv)) : wr_ptr_q;
        rd_ptr_d   = pop  ? wrap_add(rd_ptr_q, 1)       : rd_ptr_q;
    end

    // Control state: valid flag and queue pointers, cleared by reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Bundle capture: load only on an accepted handshake, otherwise hold
    always_ff @(posedge clk) begin
        if (bus.mem_to_wb_valid && allowin)
            bundle_q <= bus.mem_to_wb_zip;
    end

    // Trace queue writes; trace keeps the r0 filter but not the same-address mask
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_en[i]) begin
                tr_pc_q[push_idx[i]]    <= lane_pc[i];
                tr_waddr_q[push_idx[i]] <= lane_waddr[i];
                tr_wdata_q[push_idx[i]] <= lane_wdata[i];
                tr_we_q[push_idx[i]]    <= lane_we[i] & (lane_waddr[i] != '0);
            end
        end
    end

    // The handshake must never let a bundle push past the queue capacity
    always_ff @(posedge clk) begin
        if (resetn && fire)
            assert (int'(count_q) + int'(nv) <= DEPTH);
    end

    // RF write / forwarding bus: address and data always follow the bundle
    always_comb begin
        rf_zip = '0;
        for (int i = 0; i < LANES; i++)
            rf_zip[i*RW +: RW] = {we_eff[i], lane_waddr[i], lane_wdata[i]};
        bus.wb_rf_zip = rf_zip;
    end

    // Debug port shows the queue head, all zero when the queue is empty
    always_comb begin
        bus.wb_allowin        = allowin;
        bus.debug_wb_pc       = '0;
        bus.debug_wb_rf_we    = 4'h0;
        bus.debug_wb_rf_wnum  = '0;
        bus.debug_wb_rf_wdata = '0;
        if (pop) begin
            bus.debug_wb_pc       = tr_pc_q[rd_ptr_q];
            bus.debug_wb_rf_we    = {4{tr_we_q[rd_ptr_q]}};
            bus.debug_wb_rf_wnum  = tr_waddr_q[rd_ptr_q];
            bus.debug_wb_rf_wdata = tr_wdata_q[rd_ptr_q];
        end
    end
endmodule

// File: tb/tb_wb_stage_multilane.sv
// Directed bench for wb_stage_multilane (LANES=2, DEPTH=4).
module tb_wb_stage_multilane;
    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int AW     = 5;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 4;
    localparam int L      = 2 + AW + DATA_W + PC_W;
    localparam int RW     = 1 + AW + DATA_W;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    wb_stage_multilane_if #(.LANES(LANES), .DATA_W(DATA_W), .AW(AW), .PC_W(PC_W)) bus ();

    wb_stage_multilane #(
        .LANES(LANES), .DATA_W(DATA_W), .AW(AW), .PC_W(PC_W), .DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic              we0, we1;
    logic [DATA_W-1:0] wdata1;
    assign we0    = bus.wb_rf_zip[RW-1];
    assign we1    = bus.wb_rf_zip[2*RW-1];
    assign wdata1 = bus.wb_rf_zip[RW +: DATA_W];

    function automatic logic [L-1:0] lane(input logic v, input logic we, input logic [AW-1:0] a,
                                          input logic [DATA_W-1:0] d, input logic [PC_W-1:0] pc);
        return {v, we, a, d, pc};
    endfunction

    function automatic logic [LANES*L-1:0] stream_bundle(input int b);
        return {lane(1'b1, 1'b1, 5'd2, DATA_W'(2*b+1), PC_W'(32'h404 + 8*b)),
                lane(1'b1, 1'b1, 5'd1, DATA_W'(2*b),   PC_W'(32'h400 + 8*b))};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (drive point)
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #3;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_allowin"}, 64'(bus.wb_allowin), 64'd1);
        chk({tag, "_we0"},     64'(we0), 64'd0);
        chk({tag, "_we1"},     64'(we1), 64'd0);
        chk({tag, "_dbgwe"},   64'(bus.debug_wb_rf_we), 64'd0);
        chk({tag, "_dbgpc"},   64'(bus.debug_wb_pc), 64'd0);
        chk({tag, "_count"},   64'(dut.count_q), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  b;
        int  ntr;
        logic exp_allow [11];
        logic exp_fire  [11];
        exp_allow = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_fire  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // ---- power-on reset
        resetn = 1'b0;
        bus.mem_to_wb_valid = 1'b0;
        bus.mem_to_wb_zip   = '0;
        repeat (2) @(posedge clk);
        #1; settle();
        chk_idle("rst0");
        resetn = 1'b1;

        // ---- single bundle, two distinct writers
        cyc();
        bus.mem_to_wb_valid = 1'b1;
        bus.mem_to_wb_zip   = {lane(1, 1, 5'd4, 32'hB, 32'h104), lane(1, 1, 5'd3, 32'hA, 32'h100)};
        settle();
        chk("t2_allowin", 64'(bus.wb_allowin), 64'd1);
        cyc();
        bus.mem_to_wb_valid = 1'b0;
        settle();
        chk("t2_we0", 64'(we0), 64'd1);
        chk("t2_we1", 64'(we1), 64'd1);
        cyc(); settle();
        chk("t2_pc0",   64'(bus.debug_wb_pc), 64'h100);
        chk("t2_wnum0", 64'(bus.debug_wb_rf_wnum), 64'd3);
        chk("t2_data0", 64'(bus.debug_wb_rf_wdata), 64'hA);
        chk("t2_dwe0",  64'(bus.debug_wb_rf_we), 64'hF);
        chk("t2_we0_off", 64'(we0), 64'd0);
        cyc(); settle();
        chk("t2_pc1",   64'(bus.debug_wb_pc), 64'h104);
        chk("t2_wnum1", 64'(bus.debug_wb_rf_wnum), 64'd4);
        chk("t2_data1", 64'(bus.debug_wb_rf_wdata), 64'hB);
        cyc(); settle();
        chk("t2_empty_we", 64'(bus.debug_wb_rf_we), 64'd0);
        chk("t2_empty_pc", 64'(bus.debug_wb_pc), 64'd0);

        // ---- same-address: youngest lane wins
        bus.mem_to_wb_valid = 1'b1;
        bus.mem_to_wb_zip   = {lane(1, 1, 5'd5, 32'h2, 32'h204), lane(1, 1, 5'd5, 32'h1, 32'h200)};
        cyc();
        bus.mem_to_wb_valid = 1'b0;
        settle();
        chk("t3_we0",    64'(we0), 64'd0);
        chk("t3_we1",    64'(we1), 64'd1);
        chk("t3_wdata1", 64'(wdata1), 64'h2);
        cyc(); settle();
        chk("t3_pc0",   64'(bus.debug_wb_pc), 64'h200);
        chk("t3_data0", 64'(bus.debug_wb_rf_wdata), 64'h1);
        chk("t3_dwe0",  64'(bus.debug_wb_rf_we), 64'hF);
        cyc(); settle();
        chk("t3_pc1",   64'(bus.debug_wb_pc), 64'h204);
        chk("t3_data1", 64'(bus.debug_wb_rf_wdata), 64'h2);
        cyc(); settle();

        // ---- r0 write and we=0 lane
        bus.mem_to_wb_valid = 1'b1;
        bus.mem_to_wb_zip   = {lane(1, 0, 5'd7, 32'h6, 32'h304), lane(1, 1, 5'd0, 32'h5, 32'h300)};
        cyc();
        bus.mem_to_wb_valid = 1'b0;
        settle();
        chk("t4_we0", 64'(we0), 64'd0);
        chk("t4_we1", 64'(we1), 64'd0);
        cyc(); settle();
        chk("t4_pc0",  64'(bus.debug_wb_pc), 64'h300);
        chk("t4_dwe0", 64'(bus.debug_wb_rf_we), 64'd0);
        cyc(); settle();
        chk("t4_pc1",   64'(bus.debug_wb_pc), 64'h304);
        chk("t4_wnum1", 64'(bus.debug_wb_rf_wnum), 64'd7);
        chk("t4_dwe1",  64'(bus.debug_wb_rf_we), 64'd0);
        cyc(); settle();
        chk("t4_empty_pc", 64'(bus.debug_wb_pc), 64'd0);

        // ---- partial (lane_v=01) then empty bundle
        bus.mem_to_wb_valid = 1'b1;
        bus.mem_to_wb_zip   = {lane(0, 1, 5'd8, 32'h8, 32'h504), lane(1, 1, 5'd9, 32'h9, 32'h500)};
        cyc();
        bus.mem_to_wb_zip   = {lane(0, 1, 5'd10, 32'h10, 32'h604), lane(0, 1, 5'd11, 32'h11, 32'h600)};
        settle();
        chk("t6_we0",      64'(we0), 64'd1);
        chk("t6_we1",      64'(we1), 64'd0);
        chk("t6_allowin1", 64'(bus.wb_allowin), 64'd1);
        cyc();
        bus.mem_to_wb_valid = 1'b0;
        settle();
        chk("t6_allowin2", 64'(bus.wb_allowin), 64'd1);
        chk("t6_empty_we0", 64'(we0), 64'd0);
        chk("t6_pc",   64'(bus.debug_wb_pc), 64'h500);
        chk("t6_wnum", 64'(bus.debug_wb_rf_wnum), 64'd9);
        cyc(); settle();
        chk_idle("t6_end");

        // ---- back-pressure: MEM offers a 2-lane bundle every cycle
        b   = 0;
        ntr = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            bus.mem_to_wb_valid = (b < 6);
            bus.mem_to_wb_zip   = stream_bundle(b);
            settle();
            if (c < 11) begin
                chk($sformatf("t5_allowin_c%0d", c), 64'(bus.wb_allowin), 64'(exp_allow[c]));
                chk($sformatf("t5_fire_c%0d", c),    64'(we0), 64'(exp_fire[c]));
            end
            if (bus.debug_wb_rf_we == 4'hF) begin
                chk($sformatf("t5_trace%0d", ntr), 64'(bus.debug_wb_pc), 64'(32'h400 + 4*ntr));
                ntr++;
            end
            if (bus.mem_to_wb_valid && bus.wb_allowin) b++;
        end
        chk("t5_accepted", 64'(b), 64'd6);
        chk("t5_traced",   64'(ntr), 64'd12);
        bus.mem_to_wb_valid = 1'b0;
        settle();
        chk_idle("t5_end");

        // ---- reset asserted mid-stall with a full-ish queue
        b = 10;
        for (int c = 0; c < 4; c++) begin
            cyc();
            bus.mem_to_wb_valid = 1'b1;
            bus.mem_to_wb_zip   = stream_bundle(b);
            settle();
            if (bus.wb_allowin) b++;
        end
        chk("t1_stalled", 64'(bus.wb_allowin), 64'd0);
        resetn = 1'b0;
        #1;
        chk_idle("t1_async");
        bus.mem_to_wb_valid = 1'b0;
        cyc(); settle();
        chk_idle("t1_held");
        resetn = 1'b1;
        cyc(); settle();
        chk_idle("t1_after1");
        cyc(); settle();
        chk_idle("t1_after2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
